// File: rtl/commit_trace_streamer.sv
// Commit trace streamer: buffers retired-instruction records in a FIFO and
// serializes each one as a 14-byte frame on an 8-bit valid/ready stream.
module commit_trace_streamer #(
   parameter int         XLEN      = 32,
   parameter int         DEPTH     = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       enable_i,
   input  logic                       update_i,
   input  logic [XLEN-1:0]            pc_i,
   input  logic [XLEN-1:0]            instr_i,
   input  logic [4:0]                 reg_addr_i,
   input  logic [XLEN-1:0]            reg_data_i,
   output logic [7:0]                 tdata_o,
   output logic                       tvalid_o,
   input  logic                       tready_i,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [15:0]                drop_cnt_o,
   output logic                       busy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = 3 * XLEN + 5;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   logic [RW-1:0]   mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [15:0]     drop_cnt_r;
   logic            sticky_r;
   state_t          state_r;
   logic            tvalid_r;
   logic [3:0]      byte_idx_r;
   logic            f_drop_r;
   logic [4:0]      f_addr_r;
   logic [XLEN-1:0] f_pc_r, f_instr_r, f_data_r;

   logic            full_s, empty_s, push_s, drop_s, pop_s;
   logic [RW-1:0]   head_s;
   logic [4:0]      head_addr_s;

   function automatic logic [7:0] frame_byte(
      input logic [3:0]      idx,
      input logic            drop,
      input logic [4:0]      addr,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] instr,
      input logic [XLEN-1:0] data
   );
      case (idx)
         4'd0:    frame_byte = SYNC_BYTE;
         4'd1:    frame_byte = {drop, (addr != 5'd0), 1'b0, addr};
         4'd2:    frame_byte = pc[7:0];
         4'd3:    frame_byte = pc[15:8];
         4'd4:    frame_byte = pc[23:16];
         4'd5:    frame_byte = pc[31:24];
         4'd6:    frame_byte = instr[7:0];
         4'd7:    frame_byte = instr[15:8];
         4'd8:    frame_byte = instr[23:16];
         4'd9:    frame_byte = instr[31:24];
         4'd10:   frame_byte = data[7:0];
         4'd11:   frame_byte = data[15:8];
         4'd12:   frame_byte = data[23:16];
         4'd13:   frame_byte = data[31:24];
         default: frame_byte = 8'h00;
      endcase
   endfunction

   // Full/empty come from the pre-edge level, so a same-edge pop never rescues a push.
   assign full_s      = (level_r == LW'(DEPTH));
   assign empty_s     = (level_r == {LW{1'b0}});
   assign push_s      = update_i & enable_i & ~full_s;
   assign drop_s      = update_i & enable_i & full_s;
   assign pop_s       = ~empty_s & ((state_r == IDLE) |
                                    (tvalid_r & tready_i & (byte_idx_r == 4'd13)));
   assign head_s      = mem_r[rd_ptr_r];
   assign head_addr_s = head_s[XLEN +: 5];

   assign tvalid_o   = tvalid_r;
   assign tdata_o    = tvalid_r ? frame_byte(byte_idx_r, f_drop_r, f_addr_r,
                                             f_pc_r, f_instr_r, f_data_r) : 8'h00;
   assign level_o    = level_r;
   assign drop_cnt_o = drop_cnt_r;
   assign busy_o     = (state_r != IDLE) | ~empty_s;

   // FIFO storage write port.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {pc_i, instr_i, reg_addr_i, reg_data_i};
      end
   end

   // FIFO pointers, occupancy, drop counter and sticky drop flag.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         drop_cnt_r <= 16'h0000;
         sticky_r   <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
         if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
         // A drop on the load edge wins, so the flag carries to the next frame.
         if (drop_s)     sticky_r <= 1'b1;
         else if (pop_s) sticky_r <= 1'b0;
      end
   end

   // Frame sequencer: loads the FIFO head and walks the 14 frame bytes.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r    <= IDLE;
         tvalid_r   <= 1'b0;
         byte_idx_r <= 4'd0;
         f_drop_r   <= 1'b0;
         f_addr_r   <= 5'd0;
         f_pc_r     <= {XLEN{1'b0}};
         f_instr_r  <= {XLEN{1'b0}};
         f_data_r   <= {XLEN{1'b0}};
      end else begin
         if (pop_s) begin
            byte_idx_r <= 4'd0;
            f_drop_r   <= sticky_r;
            f_addr_r   <= head_addr_s;
            f_pc_r     <= head_s[RW-1 -: XLEN];
            f_instr_r  <= head_s[XLEN+5 +: XLEN];
            f_data_r   <= (head_addr_s == 5'd0) ? {XLEN{1'b0}} : head_s[XLEN-1:0];
         end
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r  <= SEND;
                  tvalid_r <= 1'b1;
               end
            end
            SEND: begin
               if (tvalid_r && tready_i) begin
                  if (byte_idx_r != 4'd13) begin
                     byte_idx_r <= byte_idx_r + 4'd1;
                  end else if (!pop_s) begin
                     state_r  <= IDLE;
                     tvalid_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               tvalid_r <= 1'b0;
            end
         endcase
      end
   end
endmodule
